// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, constants and helpers for the display scan controller
//
// Contents:
//   scan_state_t    : IDLE / BLANK / ON scan states
//   DEF_DIGIT_TICKS : default lit time per digit (clock cycles)
//   DEF_BLANK_TICKS : default dark time before each digit (clock cycles)
//   ANODES_OFF      : active-low anode pattern with every digit dark
//   digit_anodes()  : anode pattern for one selected digit under a mask
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    localparam int DEF_DIGIT_TICKS = 2000;
    localparam int DEF_BLANK_TICKS = 50;

    localparam logic [3:0] ANODES_OFF = 4'b1111;

    // Only the selected digit may go low, and only if its mask bit allows it,
    // so at most one anode is ever driven low.
    function automatic logic [3:0] digit_anodes(input logic [1:0] sel, input logic [3:0] mask);
        logic [3:0] a;
        a      = ANODES_OFF;
        a[sel] = ~mask[sel];
        return a;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// rtl/display_scan_controller_if.sv - control/status bundle between the scan controller and its user
//
// Signals:
//   enable     : 1 = scan running, 0 = dark and idle (user -> controller)
//   digitMask  : bit i allows digit i to light (user -> controller)
//   digitCount : digit select for the downstream 4:1 digit mux (controller -> user)
//   anodes     : active-low digit enables (controller -> user)
//   blanking   : 1 whenever anodes are all off (controller -> user)
//   frameStart : one-cycle pulse at the start of each 4-digit frame (controller -> user)
// Modports: master = user side, slave = controller side.
interface display_scan_controller_if;

    logic       enable;
    logic [3:0] digitMask;
    logic [1:0] digitCount;
    logic [3:0] anodes;
    logic       blanking;
    logic       frameStart;

    modport master (
        output enable,
        output digitMask,
        input  digitCount,
        input  anodes,
        input  blanking,
        input  frameStart
    );

    modport slave (
        input  enable,
        input  digitMask,
        output digitCount,
        output anodes,
        output blanking,
        output frameStart
    );

endinterface

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - per-state cycle counter for the scan FSM
//
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   clear : restart counting from 0 on the next edge (asserted on every state change)
//   limit : number of cycles the current state lasts (1 or more)
//   done  : high during the last cycle of the current state
module tick_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count;

    assign done = (count == (limit - WIDTH'(1)));

    // Holding at done keeps the count from ever wrapping inside a state even
    // if the owner were to ignore done for a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!done) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed 4-digit display scan FSM with blanking gaps
//
// Parameters:
//   DIGIT_TICKS : cycles each digit is lit (>= 1)
//   BLANK_TICKS : cycles all anodes are off before each digit (>= 1)
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of display_scan_controller_if (enable/digitMask in,
//           digitCount/anodes/blanking/frameStart out, all outputs registered)
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DIGIT_TICKS = DEF_DIGIT_TICKS,
    parameter int BLANK_TICKS = DEF_BLANK_TICKS
) (
    input  logic                      clk,
    input  logic                      reset,
    display_scan_controller_if.slave  bus
);

    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);

    scan_state_t state;
    logic [1:0]  digit_count;
    logic [3:0]  anodes;
    logic        blanking;
    logic        frame_start;

    logic          tick_done;
    logic          tick_clear;
    logic [CW-1:0] tick_limit;

    // The counter restarts whenever the state is about to change: leaving
    // BLANK/ON on done, dropping to IDLE on !enable, or sitting in IDLE.
    assign tick_clear = (state == IDLE) || !bus.enable || tick_done;
    assign tick_limit = (state == BLANK) ? CW'(BLANK_TICKS) : CW'(DIGIT_TICKS);

    tick_counter #(
        .WIDTH (CW)
    ) u_tick_counter (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .limit (tick_limit),
        .done  (tick_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            digit_count <= 2'd0;
            anodes      <= ANODES_OFF;
            blanking    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (!bus.enable) begin
                state       <= IDLE;
                digit_count <= 2'd0;
                anodes      <= ANODES_OFF;
                blanking    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state       <= BLANK;
                        digit_count <= 2'd0;
                        anodes      <= ANODES_OFF;
                        blanking    <= 1'b1;
                        frame_start <= 1'b1;
                    end
                    BLANK: begin
                        if (tick_done) begin
                            state    <= ON;
                            anodes   <= digit_anodes(digit_count, bus.digitMask);
                            blanking <= ~bus.digitMask[digit_count];
                        end
                    end
                    ON: begin
                        if (tick_done) begin
                            state       <= BLANK;
                            digit_count <= digit_count + 2'd1;
                            anodes      <= ANODES_OFF;
                            blanking    <= 1'b1;
                            // Wrapping from digit 3 back to 0 opens a new frame.
                            frame_start <= (digit_count == 2'd3);
                        end else begin
                            // Mask is re-sampled every lit cycle so edits show mid-digit.
                            anodes   <= digit_anodes(digit_count, bus.digitMask);
                            blanking <= ~bus.digitMask[digit_count];
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        digit_count <= 2'd0;
                        anodes      <= ANODES_OFF;
                        blanking    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.digitCount = digit_count;
    assign bus.anodes     = anodes;
    assign bus.blanking   = blanking;
    assign bus.frameStart = frame_start;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed self-checking bench for display_scan_controller
module tb_display_scan_controller;
    import display_pkg::*;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    display_scan_controller_if bus();

    display_scan_controller #(
        .DIGIT_TICKS (4),
        .BLANK_TICKS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_dark(input string tag);
        check({tag, " anodes"},     8'(bus.anodes),     8'h0f);
        check({tag, " blanking"},   8'(bus.blanking),   8'h01);
        check({tag, " digitCount"}, 8'(bus.digitCount), 8'h00);
        check({tag, " frameStart"}, 8'(bus.frameStart), 8'h00);
    endtask

    // Runs n cycles starting at the edge that enters BLANK for digit 0.
    // With 2 blank + 4 lit cycles per digit, cycle k belongs to digit (k/6)%4
    // and is lit when k%6 >= 2; the lit pattern uses the mask present at the
    // edge that opened the cycle.
    task automatic run_cycles(input int n, input bit rnd, input string tag);
        for (int k = 0; k < n; k++) begin
            logic [3:0] m;
            logic [3:0] one;
            logic [3:0] ea;
            int d;
            int pos;
            m = bus.digitMask;
            @(posedge clk);
            @(negedge clk);
            d   = (k / 6) % 4;
            pos = k % 6;
            one = 4'b0001 << d;
            if (pos < 2 || !m[d]) ea = 4'b1111;
            else ea = ~one;
            check($sformatf("%s k=%0d anodes", tag, k),     8'(bus.anodes),     8'(ea));
            check($sformatf("%s k=%0d digitCount", tag, k), 8'(bus.digitCount), 8'(d));
            check($sformatf("%s k=%0d blanking", tag, k),   8'(bus.blanking),   8'(ea == 4'b1111));
            check($sformatf("%s k=%0d frameStart", tag, k), 8'(bus.frameStart), 8'(k % 24 == 0));
            check($sformatf("%s k=%0d onehot", tag, k),     8'($countones(~bus.anodes) <= 1), 8'h01);
            if (rnd) bus.digitMask = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        passed         = 0;
        total          = 0;
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.digitMask  = 4'b1111;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_dark("reset");
        check("reset state", 8'(dut.state), 8'(IDLE));

        // Released but not enabled: stays dark in IDLE
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_dark("idle");
        check("idle state", 8'(dut.state), 8'(IDLE));

        // Basic scan, two back-to-back frames
        bus.enable = 1'b1;
        run_cycles(48, 1'b0, "basic");

        // Mask 0011: digits 3 and 2 stay dark while digitCount still steps
        bus.enable = 1'b0;
        @(negedge clk);
        check_dark("stop1");
        bus.digitMask = 4'b0011;
        bus.enable    = 1'b1;
        run_cycles(24, 1'b0, "mask");

        // Enable drop in the second lit cycle of digit 2
        bus.enable = 1'b0;
        @(negedge clk);
        bus.digitMask = 4'b1111;
        bus.enable    = 1'b1;
        run_cycles(16, 1'b0, "drop_pre");
        bus.enable = 1'b0;
        @(negedge clk);
        check_dark("drop");
        check("drop state", 8'(dut.state), 8'(IDLE));
        @(negedge clk);
        check_dark("drop_hold");
        bus.enable = 1'b1;
        run_cycles(24, 1'b0, "drop_resume");

        // Async reset between edges while digit 1 is lit
        run_cycles(9, 1'b0, "rst_pre");
        #2 reset = 1'b1;
        #1;
        check_dark("async_rst");
        @(negedge clk);
        reset = 1'b0;
        run_cycles(24, 1'b0, "rst_resume");

        // Ten frames with a fresh random mask every cycle
        run_cycles(240, 1'b1, "rand");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
